// File: rtl/mat_out_serializer.sv
// mat_out_serializer
//   Takes the 16-bit result stream from the MAT engine (one word per clock
//   while mat_ready is high) and stores it in a small FIFO. Each word is sent
//   out as two bytes, high byte first, over a valid/ack byte interface.
//   A sticky overflow flag is set if a word arrives while the FIFO is full.
//   frame_done pulses for one cycle once a burst has ended and fully drained.
//
//   Optional feature macro: MAT_SER_CHECKSUM_EN
//     When defined, an 8-bit XOR of every acked byte in the frame is sent as
//     one extra byte after the frame drains. frame_done pulses when that
//     checksum byte is acked.
//
// Ports
//   clock       sole clock, rising edge
//   reset       asynchronous, active-high reset
//   mat_out     result word from MAT, sampled when mat_ready=1
//   mat_ready   MAT output-valid level
//   byte_out    byte presented to the consumer (registered)
//   byte_valid  byte_out valid (registered)
//   byte_ack    consumer takes byte_out on an edge where byte_valid=1
//   fifo_count  words currently stored, 0..DEPTH
//   overflow    sticky, set when a word is dropped because the FIFO is full
//   frame_done  one-cycle pulse after the end of a burst has drained
module mat_out_serializer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       mat_out,
  input  logic              mat_ready,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ack,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              frame_done
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

`ifdef MAT_SER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HI, LO, CSUM} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [1:0] {IDLE, HI, LO} state_t;
`endif

  state_t            state;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_inc;
  logic [ADDR_W:0]   count;
  logic [15:0]       head;
  logic [15:0]       next_head;
  logic              pop;
  logic              push_ok;
  logic              done_cond;
  logic              mat_ready_d;
  logic              pending;

  assign fifo_count = count;
  assign head       = mem[rd_ptr];
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // The word is released when its low byte is acked.
  assign pop     = (state == LO) && byte_ack;
  // A full FIFO still accepts a word if a slot frees on the same edge.
  assign push_ok = mat_ready && ((count != FULL) || pop);

  // When the last stored word is popped while a new one is pushed, the new
  // word has not reached the array yet, so forward it straight from mat_out.
  assign next_head = (count == ONE) ? mat_out : mem[rd_ptr_inc];

  assign done_cond = pending && !mat_ready && (state == IDLE) && (count == '0);

  // Storage array: no reset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= mat_out;
  end

  // FIFO pointers, occupancy and overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr_inc;
      case ({push_ok, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (mat_ready && !push_ok) overflow <= 1'b1;
    end
  end

  // Byte serializer FSM plus frame tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      frame_done  <= 1'b0;
      pending     <= 1'b0;
      mat_ready_d <= 1'b0;
`ifdef MAT_SER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      mat_ready_d <= mat_ready;
      frame_done  <= 1'b0;
`ifndef MAT_SER_CHECKSUM_EN
      if (done_cond) begin
        frame_done <= 1'b1;
        pending    <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          byte_valid <= 1'b0;
          if (count != '0) begin
            state      <= HI;
            byte_out   <= head[15:8];
            byte_valid <= 1'b1;
          end
`ifdef MAT_SER_CHECKSUM_EN
          else if (done_cond) begin
            state      <= CSUM;
            byte_out   <= csum;
            byte_valid <= 1'b1;
          end
`endif
        end
        HI: begin
          if (byte_ack) begin
            state    <= LO;
            byte_out <= head[7:0];
`ifdef MAT_SER_CHECKSUM_EN
            csum     <= csum ^ byte_out;
`endif
          end
        end
        LO: begin
          if (byte_ack) begin
`ifdef MAT_SER_CHECKSUM_EN
            csum <= csum ^ byte_out;
`endif
            // Words remain after this pop (or one arrives on this edge).
            if ((count > ONE) || push_ok) begin
              state    <= HI;
              byte_out <= next_head[15:8];
            end else begin
              state      <= IDLE;
              byte_valid <= 1'b0;
            end
          end
        end
`ifdef MAT_SER_CHECKSUM_EN
        CSUM: begin
          if (byte_ack) begin
            state      <= IDLE;
            byte_valid <= 1'b0;
            frame_done <= 1'b1;
            csum       <= '0;
            pending    <= 1'b0;
          end
        end
`endif
        default: begin
          state      <= IDLE;
          byte_valid <= 1'b0;
        end
      endcase
      // A new end-of-burst wins over a clear on the same edge.
      if (mat_ready_d && !mat_ready) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mat_out_serializer.sv
// Testbench for mat_out_serializer (default build, checksum feature off).
// A queue-based reference model tracks stored words, the byte stream order,
// sticky overflow and the end-of-burst pulse; every cycle compares the DUT.
module tb_mat_out_serializer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [15:0]       mat_out = '0;
  logic              mat_ready = 1'b0;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ack = 1'b0;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;
  logic              frame_done;

  mat_out_serializer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .mat_out    (mat_out),
    .mat_ready  (mat_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ack   (byte_ack),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] q[$];
  bit  half;      // next byte of q[0] is the low byte
  bit  ovf;
  bit  pend;
  bit  rdy_prev;
  int  n_acc = 0;
  int  n_pops = 0;
  int  n_fd = 0;
  int  max_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    half = 0;
    ovf = 0;
    pend = 0;
    rdy_prev = 0;
  endtask

  // One clock: drive inputs at the falling edge, update model for the
  // coming rising edge, then compare outputs at the next falling edge.
  task automatic cycle(input logic rdy, input logic [15:0] w, input logic ack);
    bit acc, popping, push_ok, cond;
    logic [7:0] exp_b;
    mat_ready = rdy;
    mat_out   = w;
    byte_ack  = ack;
    acc = byte_valid && ack;
    popping = 0;
    if (acc) begin
      if (q.size() == 0) begin
        check("byte_unexpected", byte_valid, 0);
      end else begin
        exp_b = half ? q[0][7:0] : q[0][15:8];
        check("byte_out", byte_out, exp_b);
        popping = half;
        n_acc++;
      end
    end
    push_ok = rdy && ((q.size() < DEPTH) || popping);
    cond = pend && !rdy && (q.size() == 0);
    if (rdy_prev && !rdy) pend = 1;
    else if (cond) pend = 0;
    rdy_prev = rdy;
    if (acc && q.size() > 0) begin
      if (half) begin
        void'(q.pop_front());
        n_pops++;
      end
      half = !half;
    end
    if (push_ok) q.push_back(w);
    else if (rdy) ovf = 1;
    @(posedge clock);
    @(negedge clock);
    check("fifo_count", fifo_count, q.size());
    check("overflow", overflow, ovf);
    check("frame_done", frame_done, cond);
    if (q.size() == 0) check("valid_while_empty", byte_valid, 0);
    if (frame_done) n_fd++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(1'b0, 16'h0, 1'b1);
    check("drained_count", fifo_count, 0);
  endtask

  initial begin
    int fd0, acc0, pops0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    repeat (3) cycle(1'b0, 16'h0, 1'b0);

    // Single word with ack held high
    fd0 = n_fd;
    cycle(1'b1, 16'h12AB, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    check("single_hi_valid", byte_valid, 1);
    check("single_hi_byte", byte_out, 8'h12);
    cycle(1'b0, 16'h0, 1'b1);
    check("single_lo_byte", byte_out, 8'hAB);
    repeat (5) cycle(1'b0, 16'h0, 1'b1);
    check("single_fd_pulses", n_fd - fd0, 1);

    // Burst of four words, no bubbles expected
    acc0 = n_acc;
    max_cnt = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, {8'(2*i), 8'(2*i+1)}, 1'b1);
    repeat (6) cycle(1'b0, 16'h0, 1'b1);
    check("burst_bytes", n_acc - acc0, 8);
    check("burst_peak", max_cnt, 3);
    check("burst_overflow", overflow, 0);
    drain(4);

    // Fill to DEPTH, then push on the same edge as a pop
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'($urandom), 1'b0);
    check("full_count", fifo_count, DEPTH);
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'($urandom), 1'b1);
    check("full_pop_count", fifo_count, DEPTH);
    check("full_pop_overflow", overflow, 0);
    drain(40);

    // Consumer stall, 18 words into a 16-deep FIFO
    pops0 = n_pops;
    for (int i = 0; i < 18; i++) cycle(1'b1, 16'($urandom), 1'b0);
    check("stall_count", fifo_count, DEPTH);
    check("stall_overflow", overflow, 1);
    repeat (3) cycle(1'b0, 16'h0, 1'b0);
    drain(40);
    check("stall_drained_words", n_pops - pops0, DEPTH);
    check("stall_overflow_sticky", overflow, 1);

    // Asynchronous reset in the middle of a high byte with three words stored
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0);
    cycle(1'b0, 16'h0, 1'b0);
    check("pre_reset_valid", byte_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", byte_valid, 0);
    check("async_rst_count", fifo_count, 0);
    check("async_rst_overflow", overflow, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (5) cycle(1'b0, 16'h0, 1'b1);
    check("post_reset_valid", byte_valid, 0);

    // Pointer wrap: 40 words spaced every 3 cycles, ack high
    acc0 = n_acc;
    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 16'($urandom), 1'b1);
      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b1);
    end
    drain(5);
    check("wrap_bytes", n_acc - acc0, 80);
    check("wrap_max_le1", max_cnt <= 1, 1);

    // Random traffic on both sides
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 2) == 0), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    drain(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mat_out_serializer.md
Name: mat_out_serializer

Overview:
- Downstream stage of the MAT matrix engine; consumes MAT's 16-bit result stream (out/ready) one word per clock.
- Buffers words in a small FIFO and re-emits each as two bytes (high byte first) over a valid/ack byte interface toward the narrow output pad/port.
- Flags overflow when the consumer stalls too long and pulses frame_done once a MAT burst has fully drained.

Parameters:
- DEPTH, 16, FIFO depth in 16-bit words; power of two, >=2.
- ADDR_W, 4, log2(DEPTH); FIFO pointer width.

Ports:
- clock  input  1  sole clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- mat_out  input  16  result word from MAT; sampled on every rising edge where mat_ready=1.
- mat_ready  input  1  MAT output-valid level; high = one valid word per cycle.
- byte_out  output  8  byte presented to consumer.
- byte_valid  output  1  byte_out valid.
- byte_ack  input  1  consumer accepts byte_out on a rising edge where byte_valid=1.
- fifo_count  output  ADDR_W+1  words currently stored, 0..DEPTH.
- overflow  output  1  sticky; word dropped because FIFO full.
- frame_done  output  1  one-cycle pulse: burst ended and everything drained.

Behaviour:
- Reset (async assert, sync-safe deassert): FIFO empty, fifo_count=0, byte_out=0, byte_valid=0, overflow=0, frame_done=0, FSM=IDLE, frame-pending flag cleared. In-flight words/bytes discarded; reset mid-byte never completes that byte.
- Push: on rising edge with mat_ready=1, mat_out written at wr_ptr.
  - Accepted if count<DEPTH, or count==DEPTH and a pop occurs on the same edge.
  - Otherwise word dropped, pointers unchanged, overflow<=1; it stays 1 until reset.
- Pop: on the edge where the LO byte is acked. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged.
- FSM states IDLE, HI, LO. byte_out and byte_valid are registered.
  - IDLE: byte_valid=0. If count>0, go to HI with byte_out<=head[15:8] and byte_valid<=1.
  - HI: hold byte_out/byte_valid stable until byte_ack. On ack, go to LO with byte_out<=head[7:0].
  - LO: on ack, pop.
    - If post-pop count>0 (including a same-edge push), go to HI with the next head[15:8].
    - Else go to IDLE with byte_valid<=0.
- Latency: word pushed at edge N gives byte_valid=1 after edge N+1 if FSM was IDLE. With byte_ack held high, the consumer takes one byte per cycle: 2 cycles per word, back-to-back, no bubbles between words.
- byte_ack while byte_valid=0 is ignored.
- Frame tracking:
  - A falling edge of mat_ready (1 then 0 on consecutive samples) sets pending.
  - When pending=1, mat_ready=0, FSM=IDLE and count==0, frame_done pulses for exactly one cycle and pending clears.
  - If mat_ready rises again before drain, pending holds and only one pulse is issued after the later drain.
- Throughput: MAT produces 1 word/cycle but the drain rate is 1 word per 2 cycles, so a burst longer than about 2*DEPTH words overflows. Overflow is expected for full 3000-word frames unless upstream is throttled.

Optional Feature:
- MAT_SER_CHECKSUM_EN defined:
  - Adds FSM state CSUM. An 8-bit running XOR of every byte accepted (acked) is kept since the last frame_done or reset.
  - When the frame-done condition is met, the FSM enters CSUM, presents byte_out=xor with byte_valid=1, and waits for ack.
  - On ack: frame_done pulses, the XOR clears, and the FSM returns to IDLE.
  - If new words arrive while in CSUM, they wait in the FIFO until the checksum byte is acked.
- MAT_SER_CHECKSUM_EN undefined: no CSUM state, no extra byte; frame_done timing as described in Behaviour.

Test Plan:
- Reset behaviour: assert reset mid-HI with count=3 -> byte_valid=0, fifo_count=0, overflow=0 immediately (async); no byte emitted after release.
- Single word, ack held high: push 0x12AB -> byte_out 0x12 then 0xAB on consecutive cycles; byte_valid low after; frame_done pulses once, 1 cycle after drain (with checksum enabled: an extra byte 0xB9 precedes the pulse).
- Burst of 4 words 0x0001,0x0203,0x0405,0x0607 with ack high -> bytes 00 01 02 03 04 05 06 07 with no bubbles; fifo_count peaks at 3; overflow=0.
- Consumer stall: ack=0, 18 consecutive words with DEPTH=16 -> fifo_count saturates at 16, overflow=1 on word 17 and stays 1. Releasing ack then drains exactly the first 16 words in order.
- Full plus simultaneous pop: count=16 and in LO state, ack=1 with mat_ready=1 on the same edge -> new word accepted, count stays 16, overflow stays 0.
- Pointer wrap: 40 words interleaved with ack high, pushes spaced every 3 cycles -> output byte sequence matches input exactly across 2+ wraps; count never exceeds 1.
